// File: rtl/keypoint_scan_ctrl_pkg.sv
// rtl/keypoint_scan_ctrl_pkg.sv - shared SIFT scan types, state encoding and helpers
package keypoint_scan_ctrl_pkg;

    localparam int COORD_W = 10;
    localparam int SCALE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [SCALE_W-1:0] scale;
    } kp_rec_t;

    typedef struct packed {
        logic               valid;
        logic               cand;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } scan_tag_t;

    localparam int KP_REC_W = $bits(kp_rec_t);

    // Columns closer than `border` to either frame edge never yield keypoints.
    function automatic logic in_border_window(input logic [COORD_W-1:0] x,
                                              input int border, input int img_w);
        return (int'(x) >= border) && (int'(x) <= img_w - 1 - border);
    endfunction

endpackage

// File: rtl/keypoint_scan_ctrl_kp_fifo.sv
// rtl/keypoint_scan_ctrl_kp_fifo.sv - synchronous first-word-fall-through keypoint queue
module kp_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 22
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             ipush,
    input  logic [WIDTH-1:0] ipush_data,
    input  logic             ipop,
    output logic [WIDTH-1:0] odata,
    output logic             oempty,
    output logic             ofull
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // Storage write; the caller only pushes when a slot is free or one is popped this cycle.
    always_ff @(posedge iclk) begin
        if (ipush) begin
            mem[wr_ptr] <= ipush_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally on a power-of-two depth.
    always_ff @(posedge iclk) begin
        if (irst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (ipush) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (ipop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({ipush, ipop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign odata  = mem[rd_ptr];
    assign oempty = (count == '0);
    assign ofull  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/keypoint_scan_ctrl.sv
// rtl/keypoint_scan_ctrl.sv - raster scan, stability tag pipeline and keypoint queue control
module keypoint_scan_ctrl
    import keypoint_scan_ctrl_pkg::*;
#(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int LAT        = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int BORDER     = 1
) (
    input  logic         iclk,
    input  logic         irst,
    input  logic         istart,
    input  logic         ipix_valid,
    input  logic         iextrema_en,
    input  logic         istable_en,
    input  logic [1:0]   iscale,
    input  logic         okp_ready,
    output logic         okp_valid,
    output logic [9:0]   okp_x,
    output logic [9:0]   okp_y,
    output logic [1:0]   okp_scale,
    output logic         obusy,
    output logic         odone,
    output logic         ooverflow,
    output logic [15:0]  okp_count
);

    localparam int DCW = $clog2(LAT) + 1;

    scan_state_t          state;
    scan_state_t          state_nxt;
    logic [COORD_W-1:0]   x_cnt;
    logic [COORD_W-1:0]   y_cnt;
    logic [SCALE_W-1:0]   scale_q;
    logic [DCW-1:0]       drain_cnt;
    scan_tag_t            tags [LAT];
    scan_tag_t            tail;

    logic                 start_acc;
    logic                 pix_acc;
    logic                 last_pix;
    logic                 push_req;
    logic                 push_ok;
    logic                 drop;
    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    kp_rec_t              push_rec;
    kp_rec_t              rd_rec;

    assign start_acc = istart & (state == ST_IDLE);
    assign pix_acc   = ipix_valid & (state == ST_SCAN);
    assign last_pix  = pix_acc & (x_cnt == COORD_W'(IMG_W - 1)) & (y_cnt == COORD_W'(IMG_H - 1));

    // FSM state register.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and status outputs; DONE lands LAT cycles after the last pixel.
    always_comb begin
        state_nxt = state;
        obusy     = 1'b0;
        odone     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_acc) begin
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                obusy = 1'b1;
                if (last_pix) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                obusy = 1'b1;
                if (drain_cnt == DCW'(LAT - 2)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                odone     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Raster position counters and the frame's latched scale.
    always_ff @(posedge iclk) begin
        if (irst) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            scale_q <= '0;
        end else if (start_acc) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            scale_q <= iscale;
        end else if (pix_acc) begin
            if (x_cnt == COORD_W'(IMG_W - 1)) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + COORD_W'(1);
            end else begin
                x_cnt <= x_cnt + COORD_W'(1);
            end
        end
    end

    // Cycles spent in DRAIN, restarted whenever the FSM is elsewhere.
    always_ff @(posedge iclk) begin
        if (irst || state != ST_DRAIN) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + DCW'(1);
        end
    end

    // Free-running tag delay line; the tail lines up with that window's istable_en.
    always_ff @(posedge iclk) begin
        if (irst) begin
            for (int i = 0; i < LAT; i++) begin
                tags[i] <= '0;
            end
        end else begin
            tags[0] <= '{valid: pix_acc, cand: iextrema_en, x: x_cnt, y: y_cnt};
            for (int i = 1; i < LAT; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    assign tail     = tags[LAT-1];
    assign push_req = tail.valid & tail.cand & istable_en & in_border_window(tail.x, BORDER, IMG_W);
    assign pop      = okp_valid & okp_ready;
    assign push_ok  = push_req & (~fifo_full | pop);
    assign drop     = push_req & fifo_full & ~pop;
    assign push_rec = '{x: tail.x, y: tail.y, scale: scale_q};

    // Per-frame keypoint count and sticky drop flag, both cleared by a new frame.
    always_ff @(posedge iclk) begin
        if (irst || start_acc) begin
            okp_count <= '0;
            ooverflow <= 1'b0;
        end else begin
            if (push_ok && okp_count != 16'hFFFF) begin
                okp_count <= okp_count + 16'd1;
            end
            if (drop) begin
                ooverflow <= 1'b1;
            end
        end
    end

    kp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KP_REC_W)
    ) u_kp_fifo (
        .iclk       (iclk),
        .irst       (irst),
        .ipush      (push_ok),
        .ipush_data (push_rec),
        .ipop       (pop),
        .odata      (rd_rec),
        .oempty     (fifo_empty),
        .ofull      (fifo_full)
    );

    assign okp_valid = ~fifo_empty;
    assign okp_x     = rd_rec.x;
    assign okp_y     = rd_rec.y;
    assign okp_scale = rd_rec.scale;

endmodule

// File: tb/tb_keypoint_scan_ctrl.sv
// tb/tb_keypoint_scan_ctrl.sv - directed, model-checked bench for keypoint_scan_ctrl
module tb_keypoint_scan_ctrl;

    localparam int W = 8;
    localparam int H = 4;
    localparam int L = 8;
    localparam int D = 4;
    localparam int B = 1;

    logic        iclk = 1'b0;
    logic        irst;
    logic        istart;
    logic        ipix_valid;
    logic        iextrema_en;
    logic        istable_en;
    logic [1:0]  iscale;
    logic        okp_ready;
    logic        okp_valid;
    logic [9:0]  okp_x;
    logic [9:0]  okp_y;
    logic [1:0]  okp_scale;
    logic        obusy;
    logic        odone;
    logic        ooverflow;
    logic [15:0] okp_count;

    keypoint_scan_ctrl #(
        .IMG_W(W), .IMG_H(H), .LAT(L), .FIFO_DEPTH(D), .BORDER(B)
    ) dut (
        .iclk(iclk), .irst(irst), .istart(istart), .ipix_valid(ipix_valid),
        .iextrema_en(iextrema_en), .istable_en(istable_en), .iscale(iscale),
        .okp_ready(okp_ready), .okp_valid(okp_valid), .okp_x(okp_x), .okp_y(okp_y),
        .okp_scale(okp_scale), .obusy(obusy), .odone(odone), .ooverflow(ooverflow),
        .okp_count(okp_count)
    );

    always #5 iclk = ~iclk;

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    bit  chk_en = 0;
    int  rdy_mode = 1;

    // model state: queue of records, per-frame counters, history of accepted windows
    int  m_q[$];
    int  m_cnt = 0;
    bit  m_ovf = 0;
    bit  m_idle = 1;
    int  m_pix = 0;
    int  m_done_cyc = -1;
    int  m_scale = 0;
    bit  h_acc[64];
    bit  h_cand[64];
    int  h_x[64];
    int  h_y[64];
    bit  stab_sched[64];

    int  pop_log[$];
    int  first_kp_cyc;
    int  done_seen_cyc;
    int  pcyc[32];

    function automatic int rec(input int x, input int y, input int s);
        return (x << 12) | (y << 2) | s;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare DUT outputs with the model, then advance the model by this cycle's inputs.
    task automatic compare_and_model();
        bit pop;
        bit push_req;
        int t;
        if (chk_en) begin
            chk("okp_valid", okp_valid, (m_q.size() > 0));
            if (m_q.size() > 0) begin
                chk("okp_x", okp_x, (m_q[0] >> 12) & 1023);
                chk("okp_y", okp_y, (m_q[0] >> 2) & 1023);
                chk("okp_scale", okp_scale, m_q[0] & 3);
            end
            chk("obusy", obusy, (!m_idle && (m_done_cyc < 0 || cyc < m_done_cyc)));
            chk("odone", odone, (cyc == m_done_cyc));
            chk("okp_count", okp_count, m_cnt);
            chk("ooverflow", ooverflow, m_ovf);
        end
        if (okp_valid && first_kp_cyc < 0) first_kp_cyc = cyc;
        if (odone) done_seen_cyc = cyc;
        if (okp_valid && okp_ready) pop_log.push_back(rec(okp_x, okp_y, okp_scale));

        if (irst) begin
            m_q.delete();
            m_cnt = 0; m_ovf = 0; m_idle = 1; m_pix = 0; m_done_cyc = -1;
            for (int i = 0; i < 64; i++) h_acc[i] = 0;
        end else begin
            pop = (m_q.size() > 0) && okp_ready;
            push_req = 0;
            if (cyc >= L) begin
                t = (cyc - L) % 64;
                push_req = h_acc[t] && h_cand[t] && istable_en && h_x[t] >= B && h_x[t] <= W - 1 - B;
            end
            if (pop) void'(m_q.pop_front());
            if (push_req) begin
                if (m_q.size() < D) begin
                    m_q.push_back(rec(h_x[t], h_y[t], m_scale));
                    if (m_cnt < 65535) m_cnt++;
                end else begin
                    m_ovf = 1;
                end
            end
            h_acc[cyc % 64] = 0;
            if (m_idle && istart) begin
                m_idle = 0; m_scale = iscale; m_pix = 0; m_cnt = 0; m_ovf = 0; m_done_cyc = -1;
            end else if (!m_idle && m_pix < W * H && ipix_valid) begin
                h_acc[cyc % 64]  = 1;
                h_cand[cyc % 64] = iextrema_en;
                h_x[cyc % 64]    = m_pix % W;
                h_y[cyc % 64]    = m_pix / W;
                m_pix++;
                if (m_pix == W * H) m_done_cyc = cyc + L;
            end
            if (!m_idle && cyc == m_done_cyc) m_idle = 1;
        end
    endtask

    task automatic tick();
        istable_en = stab_sched[cyc % 64];
        stab_sched[cyc % 64] = 0;
        okp_ready = (rdy_mode == 1) || (rdy_mode == 2 && (cyc % 2) == 0);
        @(negedge iclk);
        compare_and_model();
        @(posedge iclk);
        #1;
        cyc++;
    endtask

    // One frame of back-to-back pixels; hmask marks candidates that the datapath calls stable.
    task automatic run_frame(input int sc, input logic [31:0] hmask, input int mid_start, input int rst_at);
        istart = 1; iscale = 2'(sc);
        tick();
        istart = 0;
        for (int p = 0; p < W * H; p++) begin
            pcyc[p] = cyc;
            if (p == rst_at) begin
                ipix_valid = 0; iextrema_en = 0; irst = 1;
                tick();
                irst = 0;
                break;
            end
            ipix_valid  = 1;
            iextrema_en = hmask[p];
            if (hmask[p]) stab_sched[(cyc + L) % 64] = 1;
            if (p == mid_start) begin
                istart = 1; iscale = 2'd3;
            end
            tick();
            istart = 0;
        end
        ipix_valid = 0; iextrema_en = 0;
        repeat (14) tick();
    endtask

    task automatic clear_obs();
        pop_log.delete();
        first_kp_cyc  = -1;
        done_seen_cyc = -1;
    endtask

    initial begin
        irst = 1; istart = 0; ipix_valid = 0; iextrema_en = 0; istable_en = 0;
        iscale = 0; okp_ready = 0;
        for (int i = 0; i < 64; i++) stab_sched[i] = 0;
        @(posedge iclk);
        #1;
        tick();
        chk_en = 1;
        tick();
        irst = 0;
        chk("rst_okp_valid", okp_valid, 0);
        chk("rst_obusy", obusy, 0);
        chk("rst_odone", odone, 0);
        chk("rst_ooverflow", ooverflow, 0);
        chk("rst_okp_count", okp_count, 0);

        // single hit at pixel 10 -> (2,1)
        rdy_mode = 1;
        clear_obs();
        run_frame(2, 32'h0000_0400, -1, -1);
        chk("hit_latency", first_kp_cyc - pcyc[10], 9);
        chk("done_latency", done_seen_cyc - pcyc[31], 8);
        chk("hit_pops", pop_log.size(), 1);
        if (pop_log.size() >= 1) chk("hit_rec", pop_log[0], rec(2, 1, 2));
        chk("hit_count", okp_count, 1);

        // border columns (0,2) and (7,2) are masked
        clear_obs();
        run_frame(1, (32'd1 << 16) | (32'd1 << 23), -1, -1);
        chk("border_pops", pop_log.size(), 0);
        chk("border_count", okp_count, 0);

        // overflow: six hits into a four-deep queue with no consumer
        rdy_mode = 0;
        clear_obs();
        run_frame(1, 32'h0000_0E0E, -1, -1);
        chk("ovf_count", okp_count, 4);
        chk("ovf_flag", ooverflow, 1);
        chk("ovf_valid", okp_valid, 1);
        rdy_mode = 1;
        repeat (8) tick();
        chk("ovf_pops", pop_log.size(), 4);
        if (pop_log.size() == 4) begin
            chk("ovf_rec0", pop_log[0], rec(1, 0, 1));
            chk("ovf_rec1", pop_log[1], rec(2, 0, 1));
            chk("ovf_rec2", pop_log[2], rec(3, 0, 1));
            chk("ovf_rec3", pop_log[3], rec(1, 1, 1));
        end

        // backpressure: ready toggling every cycle
        rdy_mode = 2;
        clear_obs();
        run_frame(0, (32'd1 << 3) | (32'd1 << 12) | (32'd1 << 21), -1, -1);
        repeat (4) tick();
        chk("bp_pops", pop_log.size(), 3);
        if (pop_log.size() == 3) begin
            chk("bp_rec0", pop_log[0], rec(3, 0, 0));
            chk("bp_rec1", pop_log[1], rec(4, 1, 0));
            chk("bp_rec2", pop_log[2], rec(5, 2, 0));
        end

        // control: stray istart mid-scan, then reset at pixel 15
        rdy_mode = 0;
        clear_obs();
        run_frame(1, 32'h0000_0002, 5, 15);
        chk("ctl_valid", okp_valid, 0);
        chk("ctl_busy", obusy, 0);
        chk("ctl_count", okp_count, 0);
        chk("ctl_pops", pop_log.size(), 0);

        rdy_mode = 1;
        clear_obs();
        run_frame(2, 32'h0000_0400, -1, -1);
        chk("next_pops", pop_log.size(), 1);
        if (pop_log.size() >= 1) chk("next_rec", pop_log[0], rec(2, 1, 2));
        chk("next_done_latency", done_seen_cyc - pcyc[31], 8);
        chk("next_busy", obusy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypoint_scan_ctrl.md
KEYPOINT_SCAN_CTRL -- requirements
Module: keypoint_scan_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 640, window-centre columns per frame.
REQ-002 SHALL have parameter IMG_H, default 480, window-centre rows per frame.
REQ-003 SHALL have parameter LAT, default 8, cycles from window sample to the matching istable_en.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, keypoint queue entries (power of two).
REQ-005 SHALL have parameter BORDER, default 1, columns masked at the left and right edges.
REQ-006 SHALL have port iclk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port irst, input, 1, reset; it is synchronous and active-high.
REQ-008 SHALL have port istart, input, 1, frame-start pulse.
REQ-009 SHALL have port ipix_valid, input, 1, one window position presented this cycle.
REQ-010 SHALL have port iextrema_en, input, 1, 26-neighbour extremum flag, aligned with ipix_valid.
REQ-011 SHALL have port istable_en, input, 1, stability result from the datapath, LAT cycles after its window.
REQ-012 SHALL have port iscale, input, 2, DoG layer index, latched on accepted istart.
REQ-013 SHALL have port okp_ready, input, 1, consumer ready.
REQ-014 SHALL have port okp_valid, output, 1, keypoint available.
REQ-015 SHALL have port okp_x, output, 10, keypoint column.
REQ-016 SHALL have port okp_y, output, 10, keypoint row.
REQ-017 SHALL have port okp_scale, output, 2, keypoint layer.
REQ-018 SHALL have port obusy, output, 1, frame in progress.
REQ-019 SHALL have port odone, output, 1, one-cycle end-of-frame pulse.
REQ-020 SHALL have port ooverflow, output, 1, sticky keypoint-drop flag.
REQ-021 SHALL have port okp_count, output, 16, keypoints queued this frame.

Function
REQ-022 SHALL implement FSM IDLE->SCAN on istart; SCAN->DRAIN when the IMG_W*IMG_H-th ipix_valid is accepted; DRAIN->DONE after LAT further cycles; DONE->IDLE after one cycle.
REQ-023 SHALL accept istart only in IDLE; on acceptance clear x, y, okp_count and ooverflow, and latch iscale.
REQ-024 SHALL accept ipix_valid only in SCAN; ignore it in every other state.
REQ-025 SHALL advance x on each accepted ipix_valid; at IMG_W-1, wrap x to 0 and increment y.
REQ-026 SHALL implement a free-running, non-stalling LAT-deep tag shift register carrying {valid, cand, x, y}; valid = accepted ipix_valid, cand = iextrema_en.
REQ-027 SHALL push {x, y, scale} into the FIFO when the tail tag has valid & cand & istable_en and BORDER <= x <= IMG_W-1-BORDER.
REQ-028 SHALL accept a push when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-029 SHALL otherwise drop the push, set ooverflow and hold it until the next accepted istart or irst.
REQ-030 SHALL increment okp_count, saturating at 16'hFFFF, on each accepted push.
REQ-031 SHALL make the FIFO first-word-fall-through: okp_valid = non-empty; pop on okp_valid & okp_ready; entry visible the cycle after its push.
REQ-032 SHALL hold okp_x, okp_y and okp_scale stable while okp_valid=1 and okp_ready=0.
REQ-033 SHALL drive obusy=1 in SCAN and DRAIN, and odone=1 only in DONE.
REQ-034 SHALL leave FIFO contents undisturbed by DONE and by a new istart.

Reset
REQ-035 SHALL, with irst=1 at a clock edge, go to IDLE, empty the FIFO, clear the tag pipeline, x, y and okp_count, and drive okp_valid=0, obusy=0, odone=0 and ooverflow=0, including mid-frame.

Structure
REQ-036 SHALL take the FSM state encoding and the keypoint record type {x, y, scale} from the shared SIFT package.
REQ-037 SHALL use one sub-module, kp_fifo (synchronous FWFT FIFO, FIFO_DEPTH entries); the FSM, counters and tag pipeline are local.

Verification (IMG_W=8, IMG_H=4, LAT=8, FIFO_DEPTH=4, BORDER=1)
REQ-038 SHALL cover reset: irst=1 for 2 cycles -> okp_valid=0, obusy=0, odone=0, ooverflow=0, okp_count=0.
REQ-039 SHALL cover single hit: 32 back-to-back pixels, cand at index 10, istable_en=1 8 cycles later, okp_ready=1 -> one keypoint (2,1,iscale) with okp_valid 9 cycles after the index-10 pixel; odone 8 cycles after the last pixel.
REQ-040 SHALL cover border mask: cand and stable at (0,2) and (7,2) -> no okp_valid; okp_count=0.
REQ-041 SHALL cover overflow: okp_ready=0, 6 qualifying hits -> 4 entries queued, okp_count=4, ooverflow=1; then okp_ready=1 drains the 4 in raster order.
REQ-042 SHALL cover backpressure: okp_ready toggling 1/0 with 3 hits -> outputs stable while stalled; order preserved; no loss.
REQ-043 SHALL cover control: istart during SCAN -> ignored; irst at pixel 15 -> IDLE, FIFO empty; the next frame runs normally.
